inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the instruction-memory interface.
- Receives a program image as a byte stream using a valid/ready handshake and assembles it into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses; PC increments by 1 per instruction.
- Holds the CPU in reset (Cpu_Hold) until the image is loaded and its checksum is verified.

Parameters:
- DEPTH, 256, number of instruction-memory words; the maximum accepted word count.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- Clk  input  1  system clock; the only clock.
- Rst  input  1  reset, synchronous and active-low.
- Start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- Rx_Data  input  8  incoming image byte.
- Rx_Valid  input  1  Rx_Data is valid.
- Rx_Ready  output  1  loader accepts a byte this cycle.
- Mem_Write  output  1  one-cycle instruction-memory write strobe.
- Mem_Address  output  32  word address of the write.
- Mem_Data  output  32  instruction word being written.
- Cpu_Hold  output  1  high keeps the CPU in reset.
- Done  output  1  load completed with a good checksum.
- Error  output  1  load failed.
- Word_Count  output  16  number of words written so far.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Rst=0 at a Clk edge forces IDLE.
- Reset values: Rx_Ready=0, Mem_Write=0, Mem_Address=0, Mem_Data=0, Done=0, Error=0, Word_Count=0, Cpu_Hold=1.
- Byte transfer: a byte is accepted on a Clk edge where Rx_Valid && Rx_Ready. Rx_Valid while Rx_Ready=0 is ignored (the byte is not lost to the sender; it must hold it).
- Image format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N words of 4 bytes each, most significant byte first.
  - One checksum byte equal to the XOR of every preceding byte, including the length bytes.
- States:
  - IDLE: Rx_Ready=0. Start -> LEN_HI, clearing Word_Count, Done, Error and the running XOR, and setting Cpu_Hold=1.
  - LEN_HI: Rx_Ready=1. On accept, latch N[15:8] -> LEN_LO.
  - LEN_LO: Rx_Ready=1. On accept, latch N[7:0]. Then:
    - N > DEPTH -> ERR.
    - N == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: Rx_Ready=1. Shift each accepted byte into the word assembler. On the 4th byte -> WRITE.
  - WRITE: Rx_Ready=0. Mem_Write=1 for exactly this cycle, with Mem_Address = BASE_ADDR + Word_Count and Mem_Data = the assembled word. At the end of the cycle Word_Count increments; if the new value == N -> CHECK, else -> DATA.
  - CHECK: Rx_Ready=1. On accept, compare the byte with the running XOR: equal -> DONE, else -> ERR.
  - DONE: Done=1, Cpu_Hold=0. Start -> LEN_HI.
  - ERR: Error=1, Cpu_Hold=1. Start -> LEN_HI.
- Timing:
  - The write strobe comes one cycle after the 4th byte of a word is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
- Signal rules:
  - Mem_Address and Mem_Data hold their last values outside WRITE.
  - Done and Error are never both 1.
  - Start while in LEN_HI through CHECK is ignored.
- Boundaries:
  - Rx_Valid=0 stalls in any receiving state indefinitely, with no timeout.
  - Word_Count wraps never: bounded by the N ≤ DEPTH check.
  - Rst=0 mid-load aborts the load: IDLE with Cpu_Hold=1. Words already written are not erased.
  - Start and Rst=0 in the same cycle: reset wins.

Decomposition:
- Package inst_loader_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR);
  - LEN_BYTES=2;
  - BYTES_PER_WORD=4.
- Sub-module word_assembler:
  - 32-bit shift register plus a 2-bit byte counter;
  - outputs word_full and the word;
  - clears on load start.

Test Plan:
- Nominal load: Start, then bytes 00 02 | 12 34 56 78 | 9A BC DE F0 | checksum (XOR of all 10 preceding bytes) 0x02, with Rx_Valid held high. Required: two writes, [0]=0x12345678 and [1]=0x9ABCDEF0; Word_Count=2; Done=1; Cpu_Hold=0; Rx_Ready=0 during each WRITE cycle.
- Bad checksum: same image with checksum 0x03. Required: both writes occur, then Error=1, Done=0, Cpu_Hold=1.
- Oversize and empty images:
  - With DEPTH=256, N=0x0101 -> ERR immediately after LEN_LO, no Mem_Write.
  - N=0 with checksum 0x00 -> DONE, no Mem_Write.
- Stalls: Rx_Valid toggles pseudo-randomly during the nominal image. Required: identical writes and final state; no byte accepted while Rx_Valid=0.
- Reset mid-load: Rst=0 for one cycle after word 1 is written. Required: all outputs return to their reset values, state IDLE. A fresh Start plus the nominal image then completes with Done=1.
- Start ignored and restart: Start pulsed during DATA has no effect. Start pulsed in DONE re-enters LEN_HI with Done=0, Cpu_Hold=1, Word_Count=0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-image loader.
// Imported by the loader top and its word assembler.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// word already includes the byte being shifted this cycle.
module inst_loader_word_assembler
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [WORD_W-9:0] sr;
  logic [1:0]        cnt;

  // The live byte completes the word, so the top can
  // capture it on the same edge as the last accept.
  assign word      = {sr, data};
  assign word_full = shift
                  && (cnt == 2'(BYTES_PER_WORD - 1));

  // Shift accepted bytes in and count position in word.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= word[WORD_W-9:0];
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed, XOR-checked program image
// into instruction memory and releases the CPU when good.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Valid,
  output logic        Rx_Ready,
  output logic        Mem_Write,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_Data,
  output logic        Cpu_Hold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] Word_Count
);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  n_rx;
  logic [7:0]        csum;
  logic [15:0]       count_nx;
  logic              accept;
  logic              go;
  logic              shift;
  logic [WORD_W-1:0] word;
  logic              word_full;

  assign accept   = Rx_Valid && Rx_Ready;
  assign go       = Start
                 && (state inside {IDLE, DONE, ERR});
  assign shift    = accept && (state == DATA);
  assign n_rx     = {len[LEN_W-1:8], Rx_Data};
  assign count_nx = Word_Count + 16'd1;

  inst_loader_word_assembler u_asm (
    .clk       (Clk),
    .rst_n     (Rst),
    .clear     (go),
    .shift     (shift),
    .data      (Rx_Data),
    .word      (word),
    .word_full (word_full)
  );

  // Load sequencer; all outputs are registered here.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state       <= IDLE;
      Rx_Ready    <= 1'b0;
      Mem_Write   <= 1'b0;
      Mem_Address <= '0;
      Mem_Data    <= '0;
      Cpu_Hold    <= 1'b1;
      Done        <= 1'b0;
      Error       <= 1'b0;
      Word_Count  <= '0;
      len         <= '0;
      csum        <= '0;
    end else begin
      Mem_Write <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (Start) begin
            state      <= LEN_HI;
            Rx_Ready   <= 1'b1;
            Cpu_Hold   <= 1'b1;
            Done       <= 1'b0;
            Error      <= 1'b0;
            Word_Count <= '0;
            csum       <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[LEN_W-1:8] <= Rx_Data;
            csum           <= csum ^ Rx_Data;
            state          <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= Rx_Data;
            csum     <= csum ^ Rx_Data;
            if ({16'd0, n_rx} > 32'(DEPTH)) begin
              state    <= ERR;
              Rx_Ready <= 1'b0;
              Error    <= 1'b1;
            end else if (n_rx == '0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum <= csum ^ Rx_Data;
            if (word_full) begin
              state       <= WRITE;
              Rx_Ready    <= 1'b0;
              Mem_Write   <= 1'b1;
              Mem_Address <= 32'(BASE_ADDR)
                           + 32'(Word_Count);
              Mem_Data    <= word;
            end
          end
        end
        WRITE: begin
          Word_Count <= count_nx;
          Rx_Ready   <= 1'b1;
          if (count_nx == len) state <= CHECK;
          else                 state <= DATA;
        end
        CHECK: begin
          if (accept) begin
            Rx_Ready <= 1'b0;
            if (Rx_Data == csum) begin
              state    <= DONE;
              Done     <= 1'b1;
              Cpu_Hold <= 1'b0;
            end else begin
              state <= ERR;
              Error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          Rx_Ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed table,
// multi-cycle corner sequences and randomized images.
module tb_inst_loader;

  localparam int DEPTH = 256;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;
  logic        Rx_Ready;
  logic        Mem_Write;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Data;
  logic        Cpu_Hold;
  logic        Done;
  logic        Error;
  logic [15:0] Word_Count;

  always #5 Clk = ~Clk;

  inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .Rx_Data     (Rx_Data),
    .Rx_Valid    (Rx_Valid),
    .Rx_Ready    (Rx_Ready),
    .Mem_Write   (Mem_Write),
    .Mem_Address (Mem_Address),
    .Mem_Data    (Mem_Data),
    .Cpu_Hold    (Cpu_Hold),
    .Done        (Done),
    .Error       (Error),
    .Word_Count  (Word_Count)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  img[$];
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];
  logic [31:0] exp_d[$];

  typedef struct {
    logic [7:0] b[11];
    int         nb;
    bit         stall;
    int         start_at;
    bit         exp_done;
    int         exp_nw;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  nom[11] = '{8'h00, 8'h02,
                          8'h12, 8'h34, 8'h56, 8'h78,
                          8'h9A, 8'hBC, 8'hDE, 8'hF0,
                          8'h02};
  logic [31:0] nom_w[2] = '{32'h12345678, 32'h9ABCDEF0};

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", Rx_Ready, 0);
    check("rst_mem_write", Mem_Write, 0);
    check("rst_mem_addr", Mem_Address, 0);
    check("rst_mem_data", Mem_Data, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_word_count", Word_Count, 0);
    check("rst_cpu_hold", Cpu_Hold, 1);
  endtask

  task automatic do_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start_done", Done, 0);
    check("start_error", Error, 0);
    check("start_hold", Cpu_Hold, 1);
    check("start_count", Word_Count, 0);
    check("start_ready", Rx_Ready, 1);
  endtask

  // Feeds img one byte per accepted handshake, logging
  // every write strobe seen, until Done/Error appears.
  task automatic run_image(input bit stall,
                           input int start_at,
                           input int stop_writes);
    int idx = 0;
    int cyc = 0;
    bit pulsed = 0;
    bit v;
    obs_a.delete();
    obs_d.delete();
    forever begin
      if (Mem_Write) begin
        obs_a.push_back(Mem_Address);
        obs_d.push_back(Mem_Data);
        check("ready_low_in_write", Rx_Ready, 0);
      end
      if (Done || Error) break;
      if (stop_writes > 0
          && obs_a.size() == stop_writes) break;
      if (cyc >= 5000) begin
        tests++;
        fails++;
        $display("FAIL timeout: got no Done/Error, expected one within 5000 cycles");
        break;
      end
      Start = (idx == start_at) && !pulsed;
      if (Start) pulsed = 1;
      v = (idx < img.size())
       && (!stall || $urandom_range(0, 2) != 0);
      Rx_Valid = v;
      if (v) Rx_Data = img[idx];
      else   Rx_Data = 8'($urandom);
      if (v && Rx_Ready) idx++;
      @(negedge Clk);
      cyc++;
    end
    Rx_Valid = 1'b0;
    Start    = 1'b0;
  endtask

  task automatic check_result(input bit ed,
                              input int ecnt);
    check("nwrites", obs_d.size(), exp_d.size());
    for (int i = 0;
         i < obs_d.size() && i < exp_d.size(); i++) begin
      check("waddr", obs_a[i], 32'(i));
      check("wdata", obs_d[i], exp_d[i]);
    end
    check("done", Done, ed);
    check("error", Error, !ed);
    check("cpu_hold", Cpu_Hold, !ed);
    check("word_count", Word_Count, ecnt);
    check("rx_ready_end", Rx_Ready, 0);
    if (exp_d.size() > 0)
      check("mem_data_hold", Mem_Data,
            exp_d[exp_d.size()-1]);
  endtask

  // Reference: parse the image by its format rules.
  function automatic void model(output bit m_done,
                                output int m_cnt);
    int n;
    logic [7:0] x;
    n = {img[0], img[1]};
    exp_d.delete();
    m_done = 0;
    m_cnt  = 0;
    if (n > DEPTH) return;
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= img[i];
    for (int w = 0; w < n; w++)
      exp_d.push_back({img[2+4*w], img[3+4*w],
                       img[4+4*w], img[5+4*w]});
    m_cnt  = n;
    m_done = (img[2+4*n] == x);
  endfunction

  task automatic load_nominal();
    img.delete();
    for (int j = 0; j < 11; j++) img.push_back(nom[j]);
    exp_d.delete();
    exp_d.push_back(nom_w[0]);
    exp_d.push_back(nom_w[1]);
  endtask

  initial begin
    bit m_done;
    int m_cnt;
    int n;
    logic [7:0] x;

    Rst = 1'b0; Start = 1'b0;
    Rx_Valid = 1'b0; Rx_Data = 8'h00;
    repeat (3) @(negedge Clk);
    check_reset_vals();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start_under_reset", Rx_Ready, 0);
    Rst = 1'b1;
    @(negedge Clk);
    check("idle_no_start", Rx_Ready, 0);

    for (int i = 0; i < 6; i++) begin
      vecs[i].b        = nom;
      vecs[i].nb       = 11;
      vecs[i].stall    = 0;
      vecs[i].start_at = -1;
      vecs[i].exp_done = 1;
      vecs[i].exp_nw   = 2;
    end
    vecs[1].b[10] = 8'h03;
    vecs[1].exp_done = 0;
    vecs[2].b[0] = 8'h01;
    vecs[2].b[1] = 8'h01;
    vecs[2].nb = 2;
    vecs[2].exp_done = 0;
    vecs[2].exp_nw = 0;
    vecs[3].b[0] = 8'h00;
    vecs[3].b[1] = 8'h00;
    vecs[3].b[2] = 8'h00;
    vecs[3].nb = 3;
    vecs[3].exp_nw = 0;
    vecs[4].stall = 1;
    vecs[5].start_at = 5;

    for (int i = 0; i < 6; i++) begin
      img.delete();
      for (int j = 0; j < vecs[i].nb; j++)
        img.push_back(vecs[i].b[j]);
      exp_d.delete();
      for (int j = 0; j < vecs[i].exp_nw; j++)
        exp_d.push_back(nom_w[j]);
      do_start();
      run_image(vecs[i].stall, vecs[i].start_at, 0);
      @(negedge Clk);
      check_result(vecs[i].exp_done, vecs[i].exp_nw);
    end

    // Reset right after the first word's write strobe.
    do_start();
    load_nominal();
    run_image(0, -1, 1);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    check_reset_vals();
    @(negedge Clk);
    check("idle_after_abort", Rx_Ready, 0);
    check("hold_after_abort", Cpu_Hold, 1);
    do_start();
    load_nominal();
    run_image(0, -1, 0);
    @(negedge Clk);
    check_result(1, 2);

    // Restart from DONE (do_start checks cleared state).
    do_start();
    load_nominal();
    run_image(1, -1, 0);
    @(negedge Clk);
    check_result(1, 2);

    for (int it = 0; it < 20; it++) begin
      img.delete();
      if (it == 0)      n = DEPTH;
      else if (it == 1) n = $urandom_range(257, 65535);
      else              n = $urandom_range(0, 6);
      img.push_back(8'(n >> 8));
      img.push_back(8'(n));
      if (n <= DEPTH) begin
        x = 8'(n >> 8) ^ 8'(n);
        for (int k = 0; k < 4 * n; k++) begin
          img.push_back(8'($urandom));
          x ^= img[img.size()-1];
        end
        if (it > 1 && $urandom_range(0, 3) == 0)
          x ^= 8'(1 << $urandom_range(0, 7));
        img.push_back(x);
      end
      model(m_done, m_cnt);
      do_start();
      run_image(it > 1 && $urandom_range(0, 1) == 1,
                -1, 0);
      @(negedge Clk);
      check_result(m_done, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
